// File: rtl/number_to_seven_seg_if.sv
// Purpose : bundles the digit-encoder data/control signals between display scanner and encoder.
// Latency : n/a (wiring only).
// Backpress: none; the encoder accepts a load every cycle.
//
// Signals:
//   number[3:0] hex digit to encode           (master -> slave)
//   load        capture strobe for number/dp  (master -> slave)
//   dp          decimal point request, 1=lit  (master -> slave)
//   blank       level, 1 = all segments unlit (master -> slave)
//   lamp_test   level, 1 = all segments lit   (master -> slave, only with LAMP_TEST_EN)
//   seg[0:7]    a,b,c,d,e,f,g,dp              (slave -> master)
//   valid       one-cycle pulse per load      (slave -> master)
// Optional feature macro: LAMP_TEST_EN
interface number_to_seven_seg_if;
    logic [3:0] number;
    logic       load;
    logic       dp;
    logic       blank;
`ifdef LAMP_TEST_EN
    logic       lamp_test;
`endif
    logic [0:7] seg;
    logic       valid;

    modport master (
`ifdef LAMP_TEST_EN
        output lamp_test,
`endif
        output number, load, dp, blank,
        input  seg, valid
    );

    modport slave (
`ifdef LAMP_TEST_EN
        input  lamp_test,
`endif
        input  number, load, dp, blank,
        output seg, valid
    );
endinterface

// File: rtl/number_to_seven_seg.sv
// Purpose : registered hex-nibble to seven-segment (+dp) encoder for one display digit.
// Latency : 1 clock from input sample edge to seg/valid.
// Backpress: none; back-to-back loads accepted every cycle, each yields its own valid pulse.
//
// Ports:
//   clk    rising-edge clock shared with the display scanner
//   rst_n  asynchronous active-low reset (seg all unlit, valid 0, held digit 0)
//   bus    number_to_seven_seg_if.slave: number/load/dp/blank[/lamp_test] in, seg/valid out
// Parameter ACTIVE_LOW: 1 = segment lit by driving 0, 0 = lit by driving 1.
// Optional feature macro: LAMP_TEST_EN (adds the lamp_test override, highest priority).
module number_to_seven_seg #(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    number_to_seven_seg_if.slave bus
);

    // All-unlit level in the output polarity.
    localparam logic [0:7] SEG_OFF = ACTIVE_LOW ? 8'hFF : 8'h00;

    logic [3:0] r_hold;
    logic       r_dp;
    logic [0:7] r_seg;
    logic       r_valid;

    logic [3:0] w_digit;
    logic       w_dp;
    logic [0:7] w_pat_al;
    logic [0:7] w_seg_al;
    logic [0:7] w_seg_next;

    // Active-low pattern, literal written seg[0]..seg[7] (a..g, dp unlit).
    function automatic logic [0:7] encode(input logic [3:0] n);
        logic [0:7] p;
        case (n)
            4'h0: p = 8'b00000011;
            4'h1: p = 8'b10011111;
            4'h2: p = 8'b00100101;
            4'h3: p = 8'b00001101;
            4'h4: p = 8'b10011001;
            4'h5: p = 8'b01001001;
            4'h6: p = 8'b01000001;
            4'h7: p = 8'b00011111;
            4'h8: p = 8'b00000001;
            4'h9: p = 8'b00001001;
            4'hA: p = 8'b00010001;
            4'hB: p = 8'b11000001;
            4'hC: p = 8'b01100011;
            4'hD: p = 8'b10000101;
            4'hE: p = 8'b01100001;
            4'hF: p = 8'b01110001;
        endcase
        return p;
    endfunction

    // A load shows its digit on the very next edge, so bypass the hold register.
    always_comb begin
        w_digit = bus.load ? bus.number : r_hold;
        w_dp    = bus.load ? bus.dp     : r_dp;
    end

    always_comb begin
        w_pat_al    = encode(w_digit);
        w_pat_al[7] = ~w_dp;
    end

    // Overrides act on the output only; the held digit is untouched so
    // releasing them restores it. Later assignment wins: lamp_test > blank.
    always_comb begin
        w_seg_al = w_pat_al;
        if (bus.blank) begin
            w_seg_al = 8'hFF;
        end
`ifdef LAMP_TEST_EN
        if (bus.lamp_test) begin
            w_seg_al = 8'h00;
        end
`endif
    end

    always_comb begin
        w_seg_next = ACTIVE_LOW ? w_seg_al : ~w_seg_al;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold  <= 4'h0;
            r_dp    <= 1'b0;
            r_seg   <= SEG_OFF;
            r_valid <= 1'b0;
        end else begin
            if (bus.load) begin
                r_hold <= bus.number;
                r_dp   <= bus.dp;
            end
            r_seg   <= w_seg_next;
            r_valid <= bus.load;
        end
    end

    assign bus.seg   = r_seg;
    assign bus.valid = r_valid;

endmodule

// File: tb/tb_number_to_seven_seg.sv
module tb_number_to_seven_seg;

`ifdef LAMP_TEST_EN
    localparam bit LAMP_EN = 1'b1;
`else
    localparam bit LAMP_EN = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] seg;   // bit7 = seg[0] (a) ... bit0 = seg[7] (dp), active-low
        logic       vld;
    } exp_t;

    typedef struct packed {
        logic [3:0] n;
        logic       ld;
        logic       p;
        logic       bl;
        logic       lt;
    } stim_t;

    logic clk;
    logic rst_n;

    number_to_seven_seg_if bus0 ();
    number_to_seven_seg_if bus1 ();

    number_to_seven_seg #(.ACTIVE_LOW(1'b1)) dut_al (.clk(clk), .rst_n(rst_n), .bus(bus0));
    number_to_seven_seg #(.ACTIVE_LOW(1'b0)) dut_ah (.clk(clk), .rst_n(rst_n), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t sb[$];
    logic [3:0] m_hold;
    logic       m_dp;

    // Active-low reference table, written seg[0]..seg[7] with dp unlit.
    logic [7:0] tbl [16] = '{
        8'b00000011, 8'b10011111, 8'b00100101, 8'b00001101,
        8'b10011001, 8'b01001001, 8'b01000001, 8'b00011111,
        8'b00000001, 8'b00001001, 8'b00010001, 8'b11000001,
        8'b01100011, 8'b10000101, 8'b01100001, 8'b01110001
    };

    // Drives both instances for one cycle and queues the expected result.
    task automatic drive(input stim_t s);
        exp_t e;
        @(negedge clk);
        bus0.number = s.n;  bus1.number = s.n;
        bus0.load   = s.ld; bus1.load   = s.ld;
        bus0.dp     = s.p;  bus1.dp     = s.p;
        bus0.blank  = s.bl; bus1.blank  = s.bl;
`ifdef LAMP_TEST_EN
        bus0.lamp_test = s.lt; bus1.lamp_test = s.lt;
`endif
        e.seg    = tbl[s.ld ? s.n : m_hold];
        e.seg[0] = ~(s.ld ? s.p : m_dp);
        if (s.lt && LAMP_EN) e.seg = 8'h00;
        else if (s.bl)       e.seg = 8'hFF;
        e.vld = s.ld;
        if (s.ld) begin
            m_hold = s.n;
            m_dp   = s.p;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        stim_t s;
        exp_t  e;
        rst_n = 1'b0;
        bus0.number = 4'h0; bus1.number = 4'h0;
        bus0.load = 1'b0;   bus1.load = 1'b0;
        bus0.dp = 1'b0;     bus1.dp = 1'b0;
        bus0.blank = 1'b0;  bus1.blank = 1'b0;
`ifdef LAMP_TEST_EN
        bus0.lamp_test = 1'b0; bus1.lamp_test = 1'b0;
`endif
        m_hold = 4'h0; m_dp = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (bus0.seg !== 8'hFF || bus0.valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_al: seg=%b valid=%b, required seg=11111111 valid=0", bus0.seg, bus0.valid);
        end
        n_checks++;
        if (bus1.seg !== 8'h00 || bus1.valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ah: seg=%b valid=%b, required seg=00000000 valid=0", bus1.seg, bus1.valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        // First edge after reset with no load shows digit 0.
        s = '{n: 4'h0, ld: 1'b0, p: 1'b0, bl: 1'b0, lt: 1'b0};
        drive(s);
        e = sb.pop_front();
        n_checks++;
        if (bus0.seg !== 8'b00000011 || bus0.valid !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset: seg=%b valid=%b, required seg=00000011 valid=0", bus0.seg, bus0.valid);
        end
        n_checks++;
        if (bus1.seg !== ~e.seg || bus1.valid !== e.vld) begin
            n_fail++;
            $display("FAIL post_reset_ah: seg=%b valid=%b, required seg=%b valid=%b", bus1.seg, bus1.valid, ~e.seg, e.vld);
        end
        // Load 1: active-high instance must show 01100000.
        s = '{n: 4'h1, ld: 1'b1, p: 1'b0, bl: 1'b0, lt: 1'b0};
        drive(s);
        e = sb.pop_front();
        n_checks++;
        if (bus1.seg !== 8'b01100000 || bus1.valid !== 1'b1) begin
            n_fail++;
            $display("FAIL ah_one: seg=%b valid=%b, required seg=01100000 valid=1", bus1.seg, bus1.valid);
        end
        n_checks++;
        if (bus0.seg !== e.seg || bus0.valid !== e.vld) begin
            n_fail++;
            $display("FAIL al_one: seg=%b valid=%b, required seg=%b valid=%b", bus0.seg, bus0.valid, e.seg, e.vld);
        end
    endtask

    task automatic test_sweep;
        exp_t e;
        for (int i = 0; i <= 16; i++) begin
            stim_t s;
            s = '{n: 4'(i), ld: (i < 16), p: 1'b0, bl: 1'b0, lt: 1'b0};
            drive(s);
            e = sb.pop_front();
            n_checks++;
            if (bus0.seg !== e.seg || bus0.valid !== e.vld) begin
                n_fail++;
                $display("FAIL sweep step %0d: seg=%b valid=%b, required seg=%b valid=%b", i, bus0.seg, bus0.valid, e.seg, e.vld);
            end
            n_checks++;
            if (bus1.seg !== ~e.seg || bus1.valid !== e.vld) begin
                n_fail++;
                $display("FAIL sweep_ah step %0d: seg=%b valid=%b, required seg=%b valid=%b", i, bus1.seg, bus1.valid, ~e.seg, e.vld);
            end
        end
        n_checks++;
        if (bus0.seg !== 8'b01110001) begin
            n_fail++;
            $display("FAIL sweep_hold_F: seg=%b, required 01110001", bus0.seg);
        end
    endtask

    task automatic test_dp;
        stim_t steps [3] = '{
            '{n: 4'h8, ld: 1'b1, p: 1'b1, bl: 1'b0, lt: 1'b0},
            '{n: 4'h2, ld: 1'b0, p: 1'b0, bl: 1'b0, lt: 1'b0},
            '{n: 4'h2, ld: 1'b1, p: 1'b0, bl: 1'b0, lt: 1'b0}
        };
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            drive(steps[i]);
            e = sb.pop_front();
            n_checks++;
            if (bus0.seg !== e.seg || bus0.valid !== e.vld) begin
                n_fail++;
                $display("FAIL dp step %0d: seg=%b valid=%b, required seg=%b valid=%b", i, bus0.seg, bus0.valid, e.seg, e.vld);
            end
            if (i == 1) begin
                n_checks++;
                if (bus0.seg !== 8'b00000000) begin
                    n_fail++;
                    $display("FAIL dp_held: seg=%b, required 00000000", bus0.seg);
                end
            end
        end
    endtask

    task automatic test_blank;
        stim_t steps [6] = '{
            '{n: 4'h3, ld: 1'b1, p: 1'b0, bl: 1'b0, lt: 1'b0},
            '{n: 4'h0, ld: 1'b0, p: 1'b0, bl: 1'b1, lt: 1'b0},
            '{n: 4'h0, ld: 1'b0, p: 1'b0, bl: 1'b0, lt: 1'b0},
            '{n: 4'h5, ld: 1'b1, p: 1'b0, bl: 1'b1, lt: 1'b0},
            '{n: 4'h0, ld: 1'b0, p: 1'b0, bl: 1'b1, lt: 1'b0},
            '{n: 4'h0, ld: 1'b0, p: 1'b0, bl: 1'b0, lt: 1'b0}
        };
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            drive(steps[i]);
            e = sb.pop_front();
            n_checks++;
            if (bus0.seg !== e.seg || bus0.valid !== e.vld) begin
                n_fail++;
                $display("FAIL blank step %0d: seg=%b valid=%b, required seg=%b valid=%b", i, bus0.seg, bus0.valid, e.seg, e.vld);
            end
            n_checks++;
            if (bus1.seg !== ~e.seg || bus1.valid !== e.vld) begin
                n_fail++;
                $display("FAIL blank_ah step %0d: seg=%b valid=%b, required seg=%b valid=%b", i, bus1.seg, bus1.valid, ~e.seg, e.vld);
            end
        end
        n_checks++;
        if (bus0.seg !== 8'b01001001) begin
            n_fail++;
            $display("FAIL blank_release_5: seg=%b, required 01001001", bus0.seg);
        end
    endtask

`ifdef LAMP_TEST_EN
    task automatic test_lamp;
        stim_t steps [3] = '{
            '{n: 4'h9, ld: 1'b1, p: 1'b0, bl: 1'b0, lt: 1'b0},
            '{n: 4'h0, ld: 1'b0, p: 1'b0, bl: 1'b1, lt: 1'b1},
            '{n: 4'h0, ld: 1'b0, p: 1'b0, bl: 1'b0, lt: 1'b0}
        };
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            drive(steps[i]);
            e = sb.pop_front();
            n_checks++;
            if (bus0.seg !== e.seg || bus0.valid !== e.vld) begin
                n_fail++;
                $display("FAIL lamp step %0d: seg=%b valid=%b, required seg=%b valid=%b", i, bus0.seg, bus0.valid, e.seg, e.vld);
            end
        end
    endtask
`endif

    task automatic test_back_to_back;
        exp_t e;
        for (int i = 0; i < 40; i++) begin
            stim_t s;
            s.n  = 4'($urandom_range(0, 15));
            s.ld = ($urandom_range(0, 3) != 0);
            s.p  = 1'($urandom_range(0, 1));
            s.bl = ($urandom_range(0, 4) == 0);
            s.lt = ($urandom_range(0, 6) == 0);
            drive(s);
            e = sb.pop_front();
            n_checks++;
            if (bus0.seg !== e.seg || bus0.valid !== e.vld) begin
                n_fail++;
                $display("FAIL b2b step %0d: seg=%b valid=%b, required seg=%b valid=%b", i, bus0.seg, bus0.valid, e.seg, e.vld);
            end
            n_checks++;
            if (bus1.seg !== ~e.seg || bus1.valid !== e.vld) begin
                n_fail++;
                $display("FAIL b2b_ah step %0d: seg=%b valid=%b, required seg=%b valid=%b", i, bus1.seg, bus1.valid, ~e.seg, e.vld);
            end
        end
    endtask

    // Reset between edges must clear outputs at once and drop a pending load.
    task automatic test_async_reset;
        stim_t s;
        exp_t  e;
        s = '{n: 4'h7, ld: 1'b1, p: 1'b1, bl: 1'b0, lt: 1'b0};
        drive(s);
        e = sb.pop_front();
        n_checks++;
        if (bus0.seg !== e.seg || bus0.valid !== e.vld) begin
            n_fail++;
            $display("FAIL pre_reset: seg=%b valid=%b, required seg=%b valid=%b", bus0.seg, bus0.valid, e.seg, e.vld);
        end
        bus0.number = 4'h9; bus1.number = 4'h9;
        bus0.load = 1'b1;   bus1.load = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus0.seg !== 8'hFF || bus0.valid !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset_al: seg=%b valid=%b, required seg=11111111 valid=0", bus0.seg, bus0.valid);
        end
        n_checks++;
        if (bus1.seg !== 8'h00 || bus1.valid !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset_ah: seg=%b valid=%b, required seg=00000000 valid=0", bus1.seg, bus1.valid);
        end
        @(posedge clk);
        @(negedge clk);
        bus0.load = 1'b0; bus1.load = 1'b0;
        rst_n  = 1'b1;
        m_hold = 4'h0;
        m_dp   = 1'b0;
        sb.delete();
        s = '{n: 4'h9, ld: 1'b0, p: 1'b0, bl: 1'b0, lt: 1'b0};
        drive(s);
        e = sb.pop_front();
        n_checks++;
        if (bus0.seg !== 8'b00000011 || bus0.valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_discard: seg=%b valid=%b, required seg=00000011 valid=0", bus0.seg, bus0.valid);
        end
        n_checks++;
        if (bus1.seg !== ~e.seg || bus1.valid !== e.vld) begin
            n_fail++;
            $display("FAIL reset_discard_ah: seg=%b valid=%b, required seg=%b valid=%b", bus1.seg, bus1.valid, ~e.seg, e.vld);
        end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_dp();
        test_blank();
`ifdef LAMP_TEST_EN
        test_lamp();
`endif
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion within 200000 time units");
        $fatal(1);
    end

endmodule
